// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encoding, default tick constants and width helper for game_sequencer
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_RUN   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_CHECK = 3'd4,
    ST_PAUSE = 3'd5,
    ST_OVER  = 3'd6
  } state_e;

  localparam int TICK_BASE_DEF = 2500000;
  localparam int TICK_MIN_DEF  = 625000;
  localparam int TICK_STEP_DEF = 125000;
  localparam int SCORE_W_DEF   = 8;

  // Bits needed to hold any value in 0..max_val
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// rtl/game_sequencer_if.sv - control/collision/status bundle between game_sequencer and its environment
interface game_sequencer_if #(
  parameter int SCORE_W = game_pkg::SCORE_W_DEF
);
  logic               start;
  logic               enter;
  logic               hit_pear;
  logic               hit_wall;
  logic               hit_body;
  logic               init;
  logic               step;
  logic               grow;
  logic               game_over;
  logic [2:0]         state;
  logic [SCORE_W-1:0] score;

  modport master (
    output start, enter, hit_pear, hit_wall, hit_body,
    input  init, step, grow, game_over, state, score
  );

  modport slave (
    input  start, enter, hit_pear, hit_wall, hit_body,
    output init, step, grow, game_over, state, score
  );
endinterface

// File: rtl/game_sequencer_step_timer.sv
// rtl/game_sequencer_step_timer.sv - step_timer: step divider plus optional speed-up (GAME_SEQUENCER_SPEEDUP_EN)
module step_timer
  import game_pkg::*;
#(
  parameter int TICK_BASE = TICK_BASE_DEF,
  parameter int TICK_MIN  = TICK_MIN_DEF,
  parameter int TICK_STEP = TICK_STEP_DEF,
  parameter int CNT_W     = cnt_width(TICK_BASE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,   // back to base period, divider at base-1
  input  logic             load,    // reload divider from current period
  input  logic             hold,    // freeze divider
  input  logic             grow,    // a pear was eaten
  output logic [CNT_W-1:0] period,
  output logic             expire
);

  localparam logic [CNT_W-1:0] BASE    = CNT_W'(TICK_BASE);
  localparam logic [CNT_W-1:0] BASE_M1 = CNT_W'(TICK_BASE - 1);

`ifdef GAME_SEQUENCER_SPEEDUP_EN
  localparam logic [CNT_W-1:0] MIN_P  = CNT_W'(TICK_MIN);
  localparam logic [CNT_W-1:0] STEP_P = CNT_W'(TICK_STEP);
  localparam logic [CNT_W:0]   FLOOR  = (CNT_W + 1)'(TICK_MIN + TICK_STEP);

  logic [CNT_W-1:0] period_q, period_d;

  // Each grow shortens the period by one step, never dropping below the minimum
  always_comb begin
    period_d = period_q;
    if (clear) begin
      period_d = BASE;
    end else if (grow) begin
      if ({1'b0, period_q} >= FLOOR) period_d = period_q - STEP_P;
      else                           period_d = MIN_P;
    end
  end

  // Period register; only consulted at divider reload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) period_q <= BASE;
    else        period_q <= period_d;
  end

  assign period = period_q;
`else
  logic unused_grow;
  assign unused_grow = grow;
  assign period      = BASE;
`endif

  logic [CNT_W-1:0] div_q, div_d;

  // Divider: clear beats reload beats freeze; parks at zero rather than wrapping
  always_comb begin
    div_d = div_q;
    if (clear)                         div_d = BASE_M1;
    else if (load)                     div_d = period - CNT_W'(1);
    else if (!hold && div_q != '0)     div_d = div_q - CNT_W'(1);
  end

  // Divider register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_q <= BASE_M1;
    else        div_q <= div_d;
  end

  assign expire = (div_q == '0);

endmodule

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - dragon game control FSM; optional speed-up via GAME_SEQUENCER_SPEEDUP_EN
module game_sequencer
  import game_pkg::*;
#(
  parameter int TICK_BASE = TICK_BASE_DEF,
  parameter int TICK_MIN  = TICK_MIN_DEF,
  parameter int TICK_STEP = TICK_STEP_DEF,
  parameter int SCORE_W   = SCORE_W_DEF
) (
  input  logic               pixel_clk,
  input  logic               rst_n,
  game_sequencer_if.slave    bus
);

  localparam int CNT_W = cnt_width(TICK_BASE);

  state_e             state_q, state_d;
  logic               wait_q, wait_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               step_c, grow_c, init_c;
  logic               t_load, t_hold, t_clear, expire;
  logic [CNT_W-1:0]   cur_period_unused;

  step_timer #(
    .TICK_BASE (TICK_BASE),
    .TICK_MIN  (TICK_MIN),
    .TICK_STEP (TICK_STEP),
    .CNT_W     (CNT_W)
  ) u_timer (
    .clk    (pixel_clk),
    .rst_n  (rst_n),
    .clear  (t_clear),
    .load   (t_load),
    .hold   (t_hold),
    .grow   (grow_c),
    .period (cur_period_unused),
    .expire (expire)
  );

  // Next state, pulses and timer controls; start low overrides everything
  always_comb begin
    state_d = state_q;
    step_c  = 1'b0;
    grow_c  = 1'b0;
    init_c  = 1'b0;
    t_load  = 1'b0;
    t_hold  = 1'b0;
    t_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        t_clear = 1'b1;
        if (bus.start) state_d = ST_INIT;
      end
      ST_INIT: begin
        init_c  = 1'b1;
        t_clear = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (expire) begin
          step_c  = 1'b1;
          t_load  = 1'b1;
          state_d = ST_WAIT;
        end else if (bus.enter) begin
          t_hold  = 1'b1;
          state_d = ST_PAUSE;
        end
      end
      ST_WAIT: begin
        if (wait_q) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (bus.hit_wall || bus.hit_body) begin
          state_d = ST_OVER;
        end else begin
          grow_c  = bus.hit_pear;
          state_d = ST_RUN;
        end
      end
      ST_PAUSE: begin
        t_hold = 1'b1;
        if (bus.enter) state_d = ST_RUN;
      end
      ST_OVER: begin
        t_hold = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (!bus.start) begin
      state_d = ST_IDLE;
      step_c  = 1'b0;
      grow_c  = 1'b0;
      init_c  = 1'b0;
      t_load  = 1'b0;
      t_hold  = 1'b0;
      t_clear = 1'b1;
    end
  end

  // WAIT phase toggle and saturating score
  always_comb begin
    wait_d  = (state_q == ST_WAIT) ? ~wait_q : 1'b0;
    score_d = score_q;
    if (init_c)                        score_d = '0;
    else if (grow_c && score_q != '1)  score_d = score_q + SCORE_W'(1);
  end

  // State, wait-phase and score registers
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wait_q  <= 1'b0;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      score_q <= score_d;
    end
  end

  assign bus.init      = init_c;
  assign bus.step      = step_c;
  assign bus.grow      = grow_c;
  assign bus.game_over = (state_q == ST_OVER);
  assign bus.state     = state_q;
  assign bus.score     = score_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - self-checking bench for game_sequencer (TICK_BASE=8, TICK_MIN=4, TICK_STEP=2)
module tb_game_sequencer;
  import game_pkg::*;

  localparam int TB = 8;
  localparam int TM = 4;
  localparam int TS = 2;

  logic clk;
  logic rst_n;

  game_sequencer_if #(.SCORE_W(8)) gif ();

  game_sequencer #(
    .TICK_BASE (TB),
    .TICK_MIN  (TM),
    .TICK_STEP (TS),
    .SCORE_W   (8)
  ) dut (
    .pixel_clk (clk),
    .rst_n     (rst_n),
    .bus       (gif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int exp_steps[$];
  bit sb_en = 1'b0;
  int grow_cnt = 0;
  int exp_c;

  typedef struct {
    logic       pear;
    logic       wall;
    logic       body;
    logic       exp_grow;
    logic [2:0] exp_state;
    int         exp_score;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_state"},     int'(gif.state),     0);
    chk({tag, "_step"},      int'(gif.step),      0);
    chk({tag, "_grow"},      int'(gif.grow),      0);
    chk({tag, "_init"},      int'(gif.init),      0);
    chk({tag, "_game_over"}, int'(gif.game_over), 0);
    chk({tag, "_score"},     int'(gif.score),     0);
  endtask

  task automatic wait_state(input logic [2:0] s, input int maxc, input string name);
    int  n;
    bit  ok;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < maxc) begin
      @(negedge clk);
      n++;
      if (gif.state == s) ok = 1'b1;
    end
    chk(name, int'(ok), 1);
  endtask

  task automatic restart(output int r);
    @(posedge clk); #1 gif.start = 1'b0;
    @(posedge clk); #1 gif.start = 1'b1;
    wait_state(ST_RUN, 10, "restart_reaches_run");
    r = cyc;
  endtask

  // Scoreboard for step pulses plus pulse exclusivity
  always @(negedge clk) begin
    if (rst_n) begin
      chk("pulse_exclusive",
          (int'(gif.step) + int'(gif.grow) + int'(gif.init) > 1) ? 1 : 0, 0);
      if (gif.grow) grow_cnt++;
      if (sb_en && gif.step) begin
        if (exp_steps.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_step: got step at cycle %0d expected none", cyc);
        end else begin
          exp_c = exp_steps.pop_front();
          chk("step_cycle", cyc, exp_c);
        end
      end
    end
  end

  int r, q, t, ld, p, last, n;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 1};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd6, 0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd6, 0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd6, 0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd6, 0};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd6, 0};

    rst_n        = 1'b0;
    gif.start    = 1'b1;
    gif.enter    = 1'b0;
    gif.hit_pear = 1'b0;
    gif.hit_wall = 1'b0;
    gif.hit_body = 1'b0;

    repeat (3) @(negedge clk);
    check_reset("reset_hold");

    // Release with start high: INIT one cycle later, then RUN
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("release_idle", int'(gif.state), 0);
    @(negedge clk);
    chk("init_state", int'(gif.state), 1);
    chk("init_pulse", int'(gif.init), 1);
    @(negedge clk);
    chk("run_state", int'(gif.state), 2);
    chk("init_done", int'(gif.init), 0);
    r = cyc;
    exp_steps.delete();
    exp_steps.push_back(r + 7);
    exp_steps.push_back(r + 15);
    exp_steps.push_back(r + 23);
    sb_en = 1'b1;
    while (cyc < r + 26) @(negedge clk);
    chk("free_run_steps_seen", exp_steps.size(), 0);
    chk("free_run_score", int'(gif.score), 0);
    sb_en = 1'b0;

    // Collision priority table; hits are held from RUN onwards and must be ignored before CHECK
    for (int i = 0; i < 7; i++) begin
      restart(r);
      exp_steps.delete();
      exp_steps.push_back(r + 7);
      sb_en = 1'b1;
      @(posedge clk); #1;
      gif.hit_pear = vecs[i].pear;
      gif.hit_wall = vecs[i].wall;
      gif.hit_body = vecs[i].body;
      wait_state(ST_CHECK, 20, "vec_reach_check");
      chk("vec_check_cycle", cyc, r + 10);
      chk("vec_grow", int'(gif.grow), int'(vecs[i].exp_grow));
      @(posedge clk); #1;
      gif.hit_pear = 1'b0;
      gif.hit_wall = 1'b0;
      gif.hit_body = 1'b0;
      @(negedge clk);
      chk("vec_state", int'(gif.state), int'(vecs[i].exp_state));
      chk("vec_game_over", int'(gif.game_over), (vecs[i].exp_state == 3'd6) ? 1 : 0);
      chk("vec_score", int'(gif.score), vecs[i].exp_score);
      if (vecs[i].exp_state == 3'd6) begin
        repeat (20) @(negedge clk);
        chk("over_holds", int'(gif.state), 6);
        chk("over_score_kept", int'(gif.score), 0);
      end
      chk("vec_steps_seen", exp_steps.size(), 0);
      sb_en = 1'b0;
    end

    // Continuous pears: step spacing follows the period model
    restart(r);
    exp_steps.delete();
    grow_cnt = 0;
    p = TB;
    t = r + 7;
    for (int k = 0; k < 6; k++) begin
      exp_steps.push_back(t);
      last = t;
      ld   = p;
`ifdef GAME_SEQUENCER_SPEEDUP_EN
      p = (p - TS < TM) ? TM : p - TS;
`endif
      t = t + ld;
    end
    sb_en = 1'b1;
    @(posedge clk); #1 gif.hit_pear = 1'b1;
    while (cyc < last + 4) @(negedge clk);
    chk("pear_steps_seen", exp_steps.size(), 0);
    chk("pear_score", int'(gif.score), 6);
    chk("pear_grow_count", grow_cnt, 6);
    sb_en = 1'b0;
    gif.hit_pear = 1'b0;

    // Pause three cycles into RUN, hold, resume
    restart(r);
    exp_steps.delete();
    sb_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 gif.enter = 1'b1;
    @(posedge clk); #1 gif.enter = 1'b0;
    @(negedge clk);
    chk("paused", int'(gif.state), 5);
    repeat (20) @(negedge clk);
    chk("still_paused", int'(gif.state), 5);
    @(posedge clk); #1 gif.enter = 1'b1;
    q = cyc;
    @(posedge clk); #1 gif.enter = 1'b0;
    exp_steps.push_back(q + 5);
    exp_steps.push_back(q + 13);
    @(negedge clk);
    chk("resumed", int'(gif.state), 2);
    wait_state(ST_WAIT, 10, "resume_reach_wait");
    @(posedge clk); #1 gif.enter = 1'b1;
    @(posedge clk); #1 gif.enter = 1'b0;
    @(negedge clk);
    chk("enter_in_wait_ignored", int'(gif.state), 4);
    while (cyc < q + 15) @(negedge clk);
    chk("pause_steps_seen", exp_steps.size(), 0);
    sb_en = 1'b0;

    // Enter in IDLE is ignored
    @(posedge clk); #1 gif.start = 1'b0; gif.enter = 1'b1;
    @(posedge clk); #1 gif.enter = 1'b0;
    @(negedge clk);
    chk("enter_in_idle_ignored", int'(gif.state), 0);

    // Score saturation
    restart(r);
    @(posedge clk); #1 gif.hit_pear = 1'b1;
    n = 0;
    while (gif.score != 8'hFF && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk("score_reaches_max", int'(gif.score), 255);
    n = 0;
    while (!gif.grow && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("extra_pear_grow", int'(gif.grow), 1);
    @(negedge clk);
    chk("score_saturated", int'(gif.score), 255);

    // Asynchronous reset in the middle of WAIT
    wait_state(ST_WAIT, 20, "sat_reach_wait");
    #1 rst_n = 1'b0;
    #1 check_reset("async_reset");
    gif.hit_pear = 1'b0;
    @(negedge clk);
    check_reset("reset_held_mid_game");

    // start dropped in the very cycle a step is due
    @(posedge clk); #1 rst_n = 1'b1;
    wait_state(ST_RUN, 10, "rerun_reach_run");
    r = cyc;
    exp_steps.delete();
    sb_en = 1'b1;
    repeat (7) @(posedge clk);
    #1 gif.start = 1'b0;
    @(negedge clk);
    chk("step_due_cycle", cyc, r + 7);
    chk("step_suppressed", int'(gif.step), 0);
    @(negedge clk);
    chk("start_low_idle", int'(gif.state), 0);
    chk("start_low_no_step", int'(gif.step), 0);
    repeat (3) @(negedge clk);
    sb_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter TICK_BASE, default 2500000, meaning the initial step period in pixel_clk cycles (10 Hz at 25 MHz).
REQ-002 SHALL have parameter TICK_MIN, default 625000, meaning the minimum step period in cycles.
REQ-003 SHALL have parameter TICK_STEP, default 125000, meaning the period decrement per pear eaten.
REQ-004 SHALL have parameter SCORE_W, default 8, meaning the score counter width.
REQ-005 SHALL have port pixel_clk, input, 1 bit: the single clock for all logic.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1 bit: game enable level from the switch; low forces IDLE.
REQ-008 SHALL have port enter, input, 1 bit: debounced pause-toggle pulse, already synchronous to pixel_clk.
REQ-009 SHALL have ports hit_pear, hit_wall and hit_body, inputs, 1 bit each: collision flags from the datapath, valid in CHECK.
REQ-010 SHALL have port init, output, 1 bit: one-cycle pulse that reloads the dragon start position and size.
REQ-011 SHALL have port step, output, 1 bit: one-cycle pulse that advances the dragon one cell.
REQ-012 SHALL have port grow, output, 1 bit: one-cycle pulse that requests a size increase and pear relocation.
REQ-013 SHALL have port game_over, output, 1 bit: high while in state OVER.
REQ-014 SHALL have port state, output, 3 bits: encoding of the current FSM state.
REQ-015 SHALL have port score, output, SCORE_W bits: count of pears eaten.

Function
REQ-016 SHALL implement the FSM states IDLE=0, INIT=1, RUN=2, WAIT=3, CHECK=4, PAUSE=5 and OVER=6.
REQ-017 SHALL transition IDLE->INIT when start=1, and INIT->RUN after exactly one cycle; init=1 only during INIT; score and the period SHALL clear in INIT.
REQ-018 In RUN, the divider SHALL count down from period-1; at 0 it SHALL assert step for one cycle, reload, and go to WAIT.
REQ-019 WAIT SHALL last exactly 2 cycles (datapath settle), then go to CHECK; the divider SHALL keep running in WAIT and CHECK.
REQ-020 CHECK SHALL last one cycle and sample the hit inputs with priority hit_wall|hit_body > hit_pear.
REQ-021 In CHECK, a wall or body hit SHALL go to OVER and emit no grow; otherwise a pear hit SHALL pulse grow in that cycle and increment score, saturating at all-ones; the state SHALL then return to RUN.
REQ-022 Hit inputs outside CHECK SHALL be ignored.
REQ-023 enter in RUN SHALL go to PAUSE with the divider frozen; enter in PAUSE SHALL return to RUN with the divider resumed from its held value; enter in WAIT, CHECK, IDLE or OVER SHALL be ignored.
REQ-024 OVER SHALL hold, emitting no step pulses, until start=0.
REQ-025 start=0 in any state SHALL go to IDLE on the next edge, overriding all other events including a same-cycle step, grow or enter.
REQ-026 step, grow and init SHALL never be high in the same cycle.

Reset
REQ-027 While rst_n=0, SHALL hold state=IDLE, step=grow=init=0, game_over=0, score=0, period=TICK_BASE and divider=TICK_BASE-1; release SHALL take effect on the next pixel_clk edge.
REQ-028 Reset asserted mid-game SHALL immediately force the reset values, with no pulse emitted.

Configuration
REQ-029 With GAME_SEQUENCER_SPEEDUP_EN defined, each grow SHALL reduce period by TICK_STEP, floored at TICK_MIN, effective at the next divider reload.
REQ-030 Without GAME_SEQUENCER_SPEEDUP_EN, period SHALL stay TICK_BASE and the speed-up logic SHALL be absent.

Structure
REQ-031 The state encoding and the default tick constants SHALL live in the shared package game_pkg.
REQ-032 The divider and speed-up logic SHALL be the sub-module step_timer, with ports load, hold, period and expire.

Verification (TICK_BASE=8, TICK_MIN=4, TICK_STEP=2)
REQ-033 Release reset with start=1 -> init at cycle 1, first step 8 cycles after RUN entry, then every 8 cycles.
REQ-034 hit_pear=1 during CHECK -> grow pulse, score 0->1; with macro, next period 6, then 4, then stays 4.
REQ-035 hit_pear=1 and hit_body=1 in the same CHECK -> OVER, game_over=1, no grow, score unchanged, no further step.
REQ-036 enter 3 cycles into RUN, hold 20 cycles, enter again -> no step while paused; next step 5 cycles after resume.
REQ-037 Drive score to 255 (SCORE_W=8) plus one more pear -> score stays 255.
REQ-038 start=0 in the same cycle as step-due, and rst_n pulsed mid-WAIT -> IDLE with no step; all outputs at reset values.
